// File: rtl/opc5ls_uart_if.sv
// CPU-side bus of the opc5ls UART: address, write data and direction from the CPU,
// plus the combinational select and read data returned to the din mux.
interface opc5ls_uart_if;
  logic [15:0] address;
  logic [15:0] wdata;
  logic        rnw;
  logic        sel;
  logic [15:0] rdata;

  modport master (output address, wdata, rnw, input sel, rdata);
  modport slave  (input address, wdata, rnw, output sel, rdata);
endinterface

// File: rtl/opc5ls_uart.sv
// Memory-mapped UART for the opc5ls bus: TX/RX FIFOs, shifters, baud divisor, sticky flags.
// Define OPC5LS_UART_PARITY_EN for an even-parity bit in each frame.
module opc5ls_uart #(
  parameter logic [15:0] BASE_ADDR   = 16'hFE00,
  parameter logic [15:0] DEFAULT_DIV = 16'd433,
  parameter int unsigned FIFO_AW     = 2
) (
  input  logic         clk,
  input  logic         reset,
  opc5ls_uart_if.slave bus,
  output logic         txd,
  input  logic         rxd,
  output logic         irq
);
  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DepthCnt = (FIFO_AW + 1)'(Depth);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic [1:0] w_off;
  logic       w_wr, w_rd, w_unused_wdata;
  logic [15:0] r_div;

  assign bus.sel = ({1'b0, bus.address} >= {1'b0, BASE_ADDR}) &&
                   ({1'b0, bus.address} <= ({1'b0, BASE_ADDR} + 17'd3));
  assign w_off = bus.address[1:0] - BASE_ADDR[1:0];
  assign w_wr  = bus.sel & ~bus.rnw;
  assign w_rd  = bus.sel & bus.rnw;
  assign w_unused_wdata = ^{bus.wdata[15:8], bus.wdata[5]};

  // ---------------- TX FIFO ----------------
  logic [7:0]         r_tx_mem [Depth];
  logic [FIFO_AW-1:0] r_tx_wp, r_tx_rp;
  logic [FIFO_AW:0]   r_tx_cnt;
  logic               w_tx_push, w_tx_pop, w_tx_full;

  assign w_tx_full = (r_tx_cnt == DepthCnt);
  assign w_tx_push = w_wr && (w_off == 2'd0) && !w_tx_full;

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + 1'b1;
      else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - 1'b1;
    end
  end

  // ---------------- TX shifter ----------------
  state_e      r_tx_st, w_tx_st_d;
  logic [15:0] r_tx_bcnt, w_tx_bcnt_d;
  logic [2:0]  r_tx_nbit, w_tx_nbit_d;
  logic [7:0]  r_tx_sh, w_tx_sh_d;
  logic        r_txd, w_txd_d;
`ifdef OPC5LS_UART_PARITY_EN
  logic        r_tx_par, w_tx_par_d;
`endif

  always_comb begin
    w_tx_st_d   = r_tx_st;
    w_tx_bcnt_d = r_tx_bcnt;
    w_tx_nbit_d = r_tx_nbit;
    w_tx_sh_d   = r_tx_sh;
    w_tx_pop    = 1'b0;
`ifdef OPC5LS_UART_PARITY_EN
    w_tx_par_d  = r_tx_par;
`endif
    if (r_tx_st != StIdle && r_tx_bcnt != 16'd0) begin
      w_tx_bcnt_d = r_tx_bcnt - 16'd1;
    end else begin
      w_tx_bcnt_d = r_div;
      case (r_tx_st)
        StIdle, StStop: begin
          w_tx_st_d = StIdle;
          if (r_tx_cnt != '0) begin
            w_tx_pop  = 1'b1;
            w_tx_sh_d = r_tx_mem[r_tx_rp];
            w_tx_st_d = StStart;
`ifdef OPC5LS_UART_PARITY_EN
            w_tx_par_d = ^r_tx_mem[r_tx_rp];
`endif
          end
        end
        StStart: begin
          w_tx_st_d   = StData;
          w_tx_nbit_d = 3'd0;
        end
        StData: begin
          w_tx_sh_d   = {1'b0, r_tx_sh[7:1]};
          w_tx_nbit_d = r_tx_nbit + 3'd1;
          if (r_tx_nbit == 3'd7) begin
`ifdef OPC5LS_UART_PARITY_EN
            w_tx_st_d = StParity;
`else
            w_tx_st_d = StStop;
`endif
          end
        end
`ifdef OPC5LS_UART_PARITY_EN
        StParity: w_tx_st_d = StStop;
`endif
        default: w_tx_st_d = StIdle;
      endcase
    end
    // txd is registered from the next state so it changes cleanly on the edge
    case (w_tx_st_d)
      StStart:  w_txd_d = 1'b0;
      StData:   w_txd_d = w_tx_sh_d[0];
`ifdef OPC5LS_UART_PARITY_EN
      StParity: w_txd_d = w_tx_par_d;
`endif
      default:  w_txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_st   <= StIdle;
      r_tx_bcnt <= '0;
      r_tx_nbit <= '0;
      r_tx_sh   <= '0;
      r_txd     <= 1'b1;
`ifdef OPC5LS_UART_PARITY_EN
      r_tx_par  <= 1'b0;
`endif
    end else begin
      r_tx_st   <= w_tx_st_d;
      r_tx_bcnt <= w_tx_bcnt_d;
      r_tx_nbit <= w_tx_nbit_d;
      r_tx_sh   <= w_tx_sh_d;
      r_txd     <= w_txd_d;
`ifdef OPC5LS_UART_PARITY_EN
      r_tx_par  <= w_tx_par_d;
`endif
    end
  end

  assign txd = r_txd;

  // ---------------- RX deserialiser ----------------
  logic        r_rx_s1, r_rx_s2, r_rx_s3;
  state_e      r_rx_st, w_rx_st_d;
  logic [15:0] r_rx_bcnt, w_rx_bcnt_d;
  logic [2:0]  r_rx_nbit, w_rx_nbit_d;
  logic [7:0]  r_rx_sh, w_rx_sh_d;
  logic        w_rx_good, w_rx_ferr, w_rx_perr;
`ifdef OPC5LS_UART_PARITY_EN
  logic        r_rx_pbit, w_rx_pbit_d;
`endif

  always_comb begin
    w_rx_st_d   = r_rx_st;
    w_rx_bcnt_d = r_rx_bcnt;
    w_rx_nbit_d = r_rx_nbit;
    w_rx_sh_d   = r_rx_sh;
    w_rx_good   = 1'b0;
    w_rx_ferr   = 1'b0;
    w_rx_perr   = 1'b0;
`ifdef OPC5LS_UART_PARITY_EN
    w_rx_pbit_d = r_rx_pbit;
`endif
    if (r_rx_st != StIdle && r_rx_bcnt != 16'd0) begin
      w_rx_bcnt_d = r_rx_bcnt - 16'd1;
    end else begin
      w_rx_bcnt_d = r_div;
      case (r_rx_st)
        StIdle: begin
          if (r_rx_s3 && !r_rx_s2) begin
            w_rx_st_d   = StStart;
            w_rx_bcnt_d = {1'b0, r_div[15:1]};
          end
        end
        StStart: begin
          w_rx_st_d   = r_rx_s2 ? StIdle : StData;
          w_rx_nbit_d = 3'd0;
        end
        StData: begin
          w_rx_sh_d   = {r_rx_s2, r_rx_sh[7:1]};
          w_rx_nbit_d = r_rx_nbit + 3'd1;
          if (r_rx_nbit == 3'd7) begin
`ifdef OPC5LS_UART_PARITY_EN
            w_rx_st_d = StParity;
`else
            w_rx_st_d = StStop;
`endif
          end
        end
`ifdef OPC5LS_UART_PARITY_EN
        StParity: begin
          w_rx_pbit_d = r_rx_s2;
          w_rx_st_d   = StStop;
        end
`endif
        StStop: begin
          w_rx_st_d = StIdle;
          if (!r_rx_s2) w_rx_ferr = 1'b1;
`ifdef OPC5LS_UART_PARITY_EN
          else if (r_rx_pbit != ^r_rx_sh) w_rx_perr = 1'b1;
`endif
          else w_rx_good = 1'b1;
        end
        default: w_rx_st_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_s3   <= 1'b1;
      r_rx_st   <= StIdle;
      r_rx_bcnt <= '0;
      r_rx_nbit <= '0;
      r_rx_sh   <= '0;
`ifdef OPC5LS_UART_PARITY_EN
      r_rx_pbit <= 1'b0;
`endif
    end else begin
      r_rx_s1   <= rxd;
      r_rx_s2   <= r_rx_s1;
      r_rx_s3   <= r_rx_s2;
      r_rx_st   <= w_rx_st_d;
      r_rx_bcnt <= w_rx_bcnt_d;
      r_rx_nbit <= w_rx_nbit_d;
      r_rx_sh   <= w_rx_sh_d;
`ifdef OPC5LS_UART_PARITY_EN
      r_rx_pbit <= w_rx_pbit_d;
`endif
    end
  end

  // ---------------- RX FIFO, flags, divisor ----------------
  logic [7:0]         r_rx_mem [Depth];
  logic [FIFO_AW-1:0] r_rx_wp, r_rx_rp;
  logic [FIFO_AW:0]   r_rx_cnt;
  logic               w_rx_push, w_rx_pop, w_rx_full, w_rx_avail, w_ovr_set, w_stat_wr;
  logic               r_ovr, r_ferr, w_perr;

  assign w_rx_avail = (r_rx_cnt != '0);
  assign w_rx_full  = (r_rx_cnt == DepthCnt);
  assign w_rx_pop   = w_rd && (w_off == 2'd0) && w_rx_avail;
  // A full FIFO still accepts the byte when the CPU pops in the same cycle
  assign w_rx_push  = w_rx_good && (!w_rx_full || w_rx_pop);
  assign w_ovr_set  = w_rx_good && w_rx_full && !w_rx_pop;
  assign w_stat_wr  = w_wr && (w_off == 2'd1);

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wp] <= r_rx_sh;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
      r_ovr    <= 1'b0;
      r_ferr   <= 1'b0;
      r_div    <= DEFAULT_DIV;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
      else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - 1'b1;
      r_ovr  <= w_ovr_set | (r_ovr  & ~(w_stat_wr & bus.wdata[3]));
      r_ferr <= w_rx_ferr | (r_ferr & ~(w_stat_wr & bus.wdata[4]));
      if (w_wr && (w_off == 2'd2)) r_div <= bus.wdata;
    end
  end

`ifdef OPC5LS_UART_PARITY_EN
  logic r_perr;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_perr <= 1'b0;
    else       r_perr <= w_rx_perr | (r_perr & ~(w_stat_wr & bus.wdata[5]));
  end
  assign w_perr = r_perr;
`else
  logic w_unused_perr;
  assign w_unused_perr = w_rx_perr;
  assign w_perr = 1'b0;
`endif

  always_comb begin
    bus.rdata = 16'h0000;
    if (bus.sel) begin
      case (w_off)
        2'd0: if (w_rx_avail) bus.rdata = {8'h00, r_rx_mem[r_rx_rp]};
        2'd1: bus.rdata = {10'h000, w_perr, r_ferr, r_ovr,
                           (r_tx_cnt == '0) && (r_tx_st == StIdle), w_tx_full, w_rx_avail};
        2'd2: bus.rdata = r_div;
        default: bus.rdata = 16'h0000;
      endcase
    end
  end

  assign irq = w_rx_avail;
endmodule

// File: tb/tb_opc5ls_uart.sv
// Scoreboard bench for opc5ls_uart: a byte-level model predicts register reads and txd
// frames; read and line monitors pop expectations and compare independently of stimulus.
module tb_opc5ls_uart;
  localparam logic [15:0] Base = 16'hFE00;

  logic clk = 1'b0;
  logic reset;
  logic txd, rxd, irq;
  logic loop_en, rxd_drv;

  opc5ls_uart_if bus ();
  assign rxd = loop_en ? txd : rxd_drv;

  opc5ls_uart dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .txd   (txd),
    .rxd   (rxd),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] q_rd[$];
  logic [7:0]  q_tx[$];
  logic [7:0]  m_rx[$];
  bit          m_ovr = 0, m_ferr = 0;
  int          cur_div = 433;
  bit          mon_en = 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  task automatic m_send(input logic [7:0] b);
    q_tx.push_back(b);
    if (loop_en) begin
      if (m_rx.size() < 4) m_rx.push_back(b);
      else m_ovr = 1;
    end
  endtask

  function automatic logic [15:0] m_status(input bit tx_idle, input bit tx_full);
    return {10'h000, 1'b0, m_ferr, m_ovr, tx_idle, tx_full, m_rx.size() != 0};
  endfunction

  function automatic int frame_bits();
`ifdef OPC5LS_UART_PARITY_EN
    return 11;
`else
    return 10;
`endif
  endfunction

  // ---------------- bus driver (entered and left at posedge+1) ----------------
  task automatic idle_bus();
    bus.address = 16'h0000;
    bus.rnw     = 1'b1;
    bus.wdata   = 16'h0000;
  endtask

  task automatic wr(input logic [1:0] off, input logic [15:0] d);
    bus.address = Base + 16'(off);
    bus.rnw     = 1'b0;
    bus.wdata   = d;
    @(posedge clk); #1;
    idle_bus();
  endtask

  task automatic rd(input logic [1:0] off, input logic [15:0] exp);
    q_rd.push_back(exp);
    bus.address = Base + 16'(off);
    bus.rnw     = 1'b1;
    @(posedge clk); #1;
    idle_bus();
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_div(input int d);
    wr(2'd2, 16'(d));
    cur_div = d;
  endtask

  task automatic send(input logic [7:0] b);
    wr(2'd0, {8'($urandom), b});
    m_send(b);
  endtask

  task automatic wait_frames(input int n);
    wait_cyc(n * frame_bits() * (cur_div + 1) + 12);
  endtask

  task automatic drain_rx();
    while (m_rx.size() != 0) rd(2'd0, {8'h00, m_rx.pop_front()});
  endtask

  task automatic chk_irq(input logic exp);
    @(negedge clk);
    check("irq", {15'h0, irq}, {15'h0, exp});
    @(posedge clk); #1;
  endtask

  task automatic drive_rx_frame(input logic [7:0] b, input logic stop_bit, input int per);
    rxd_drv = 1'b0;
    wait_cyc(per);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      wait_cyc(per);
    end
`ifdef OPC5LS_UART_PARITY_EN
    rxd_drv = ^b;
    wait_cyc(per);
`endif
    rxd_drv = stop_bit;
    wait_cyc(per);
    rxd_drv = 1'b1;
    wait_cyc(2 * per);
  endtask

  // ---------------- read monitor ----------------
  always @(negedge clk) begin
    if (bus.sel === 1'b1 && bus.rnw === 1'b1) begin
      if (q_rd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected read: addr %h got %h expected none", bus.address, bus.rdata);
      end else begin
        check($sformatf("read %h", bus.address), bus.rdata, q_rd.pop_front());
      end
    end
  end

  // ---------------- txd line monitor: checks every clock of every frame ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && txd === 1'b0) begin
        logic [10:0] fr;
        logic [7:0]  b;
        int per, nb, bad, first_k;
        bit aborted;
        per = cur_div + 1;
        nb = frame_bits();
        bad = 0;
        first_k = -1;
        aborted = 0;
        if (q_tx.size() == 0) begin
          b = 8'h00;
          checks++;
          errors++;
          $display("FAIL unexpected txd frame: got start bit expected idle at %0t", $time);
        end else begin
          b = q_tx.pop_front();
        end
        fr = '1;
        fr[0] = 1'b0;
        fr[8:1] = b;
`ifdef OPC5LS_UART_PARITY_EN
        fr[9] = ^b;
`endif
        for (int k = 0; k < nb * per; k++) begin
          if (!mon_en) begin
            aborted = 1;
            break;
          end
          if (txd !== fr[k / per]) begin
            bad++;
            if (first_k < 0) first_k = k;
          end
          if (k != nb * per - 1) @(negedge clk);
        end
        if (!aborted) begin
          checks++;
          if (bad != 0) begin
            errors++;
            $display("FAIL txd frame %h: got %0d wrong clocks (first at clock %0d) expected 0",
                     b, bad, first_k);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int c;
    logic [7:0] b;
    reset = 1'b1;
    loop_en = 1'b0;
    rxd_drv = 1'b1;
    idle_bus();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("txd in reset", {15'h0, txd}, 16'h0001);
    check("irq in reset", {15'h0, irq}, 16'h0000);
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset state and register map
    rd(2'd1, 16'h0004);
    rd(2'd2, 16'd433);
    rd(2'd3, 16'h0000);
    wr(2'd3, 16'hFFFF);
    rd(2'd3, 16'h0000);
    rd(2'd0, 16'h0000);
    chk_irq(1'b0);

    // Exact TX frame and start latency
    set_div(3);
    send(8'hA5);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (txd !== 1'b0 && c < 20);
    check("tx start latency", 16'(c), 16'd2);
    @(posedge clk); #1;
    rd(2'd1, m_status(0, 0));
    wait_frames(1);
    rd(2'd1, m_status(1, 0));

    // Loopback single byte, irq and empty read
    loop_en = 1'b1;
    send(8'h3C);
    wait_frames(1);
    chk_irq(1'b1);
    rd(2'd1, m_status(1, 0));
    drain_rx();
    chk_irq(1'b0);
    rd(2'd0, 16'h0000);

    // Burst of six writes: FIFO plus shifter take five, the sixth is dropped
    loop_en = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      wr(2'd0, 16'(i));
      if (i <= 5) m_send(8'(i));
    end
    rd(2'd1, m_status(0, 1));
    wait_frames(5);
    rd(2'd1, m_status(1, 0));

    // RX overrun on the fifth unread byte, then clear
    loop_en = 1'b1;
    for (int i = 0; i < 5; i++) send(8'($urandom));
    wait_frames(5);
    rd(2'd1, m_status(1, 0));
    drain_rx();
    rd(2'd1, m_status(1, 0));
    wr(2'd1, 16'h0008);
    m_ovr = 0;
    rd(2'd1, m_status(1, 0));

    // False start and framing error with an externally driven line
    loop_en = 1'b0;
    set_div(7);
    rxd_drv = 1'b0;
    wait_cyc(2);
    rxd_drv = 1'b1;
    wait_cyc(40);
    rd(2'd1, m_status(1, 0));
    chk_irq(1'b0);
    drive_rx_frame(8'h96, 1'b0, 8);
    m_ferr = 1;
    rd(2'd1, m_status(1, 0));
    chk_irq(1'b0);
    rd(2'd0, 16'h0000);
    wr(2'd1, 16'h0010);
    m_ferr = 0;
    rd(2'd1, m_status(1, 0));
    drive_rx_frame(8'h5A, 1'b1, 8);
    m_rx.push_back(8'h5A);
    rd(2'd1, m_status(1, 0));
    drain_rx();

    // Randomised loopback bursts with random divisors
    loop_en = 1'b1;
    for (int it = 0; it < 8; it++) begin
      int n;
      set_div(int'($urandom_range(6, 1)));
      n = int'($urandom_range(4, 1));
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        send(b);
      end
      wait_frames(n);
      rd(2'd1, m_status(1, 0));
      drain_rx();
      rd(2'd0, 16'h0000);
    end

    // Reset mid-frame: txd must rise without a clock edge
    loop_en = 1'b0;
    mon_en = 0;
    set_div(7);
    wr(2'd0, 16'h0055);
    wait_cyc(10);
    #2;
    reset = 1'b1;
    #1;
    check("txd async reset", {15'h0, txd}, 16'h0001);
    @(posedge clk); #1;
    reset = 1'b0;
    cur_div = 433;
    rd(2'd1, 16'h0004);
    rd(2'd2, 16'd433);
    mon_en = 1;
    wait_cyc(20);

    check("read queue empty", 16'(q_rd.size()), 16'd0);
    check("tx queue empty", 16'(q_tx.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
